// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA round-robin arbiter for the single-port data RAM
// Optional DMA burst lock is compiled in with `define DMEM_ARB_BURST_LOCK_EN.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_CORE = 2'd1,
        RSP_DMA  = 2'd2
    } rsp_t;

    rsp_t rsp, rsp_nxt;
    logic last;      // 0: core took the last accept, 1: DMA did
    logic dma_pri;   // DMA holds priority through a burst lock

`ifdef DMEM_ARB_BURST_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    logic [CW-1:0] lock_cnt;

    // Priority only while a lock started by an earlier DMA accept is still live.
    assign dma_pri = d_req & d_lock & (lock_cnt != '0) & (lock_cnt < LOCK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (c_gnt || !d_lock) begin
            lock_cnt <= '0;
        end else if (d_gnt) begin
            // A DMA accept after exhaustion starts a fresh lock window.
            lock_cnt <= (lock_cnt >= LOCK_MAX) ? CW'(1) : lock_cnt + CW'(1);
        end
    end

    logic [3:0] unused_addr;
    assign unused_addr = {c_addr[1:0], d_addr[1:0]};
`else
    assign dma_pri = 1'b0;

    logic [4:0] unused_cfg;
    assign unused_cfg = {c_addr[1:0], d_addr[1:0], d_lock ^ (MAX_LOCK == 0)};
`endif

    assign c_gnt   = c_req & (~d_req | (last & ~dma_pri));
    assign d_gnt   = d_req & ~c_gnt;
    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr[AW-1:2];
            mem_wdata = c_wdata;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (c_gnt) begin
            last <= 1'b0;
        end else if (d_gnt) begin
            last <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp <= RSP_NONE;
        end else begin
            rsp <= rsp_nxt;
        end
    end

    always_comb begin
        rsp_nxt = RSP_NONE;
        if (c_gnt && !c_we) begin
            rsp_nxt = RSP_CORE;
        end else if (d_gnt && !d_we) begin
            rsp_nxt = RSP_DMA;
        end
    end

    assign c_rvalid = (rsp == RSP_CORE);
    assign d_rvalid = (rsp == RSP_DMA);
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule
